// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   - loader_state_t : loader FSM encoding (also exposed on the debug State port)
//   - IW_DEFAULT     : instruction address width shared with the instruction memory
//   - DW_DEFAULT     : machine-code word width shared with the instruction memory
package inst_loader_pkg;

    localparam int IW_DEFAULT = 10;
    localparam int DW_DEFAULT = 9;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        BODY,
        CHK,
        FIN
    } loader_state_t;

endpackage

// File: rtl/inst_loader.sv
// Program loader for the single-cycle core's writable instruction memory.
// Accepts a framed stream (length word, N instruction words, XOR checksum
// word), writes the instructions from address 0 upward, holds the core in
// reset for the whole session and reports Done / Error at the end.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset_n    in   synchronous active-low reset
//   Start      in   begins a session; only looked at in IDLE
//   InData     in   DW-bit stream word
//   InValid    in   InData is valid
//   InReady    out  loader can accept a word (depends on state only)
//   WrEn       out  instruction-memory write strobe (registered)
//   WrAddress  out  IW-bit write address (registered)
//   WrData     out  DW-bit write data (registered)
//   CpuHold    out  keeps the core in reset while high
//   Done       out  one-cycle completion pulse (the FIN cycle)
//   Error      out  sticky session error, cleared by the next accepted Start
//   State      out  current FSM state, for debug/observation
//
// Handshake: a word is transferred on a rising edge where InValid && InReady.
// InValid without InReady consumes nothing; InValid low stalls any state.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int IW = IW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [DW-1:0] InData,
    input  logic          InValid,
    output logic          InReady,
    output logic          WrEn,
    output logic [IW-1:0] WrAddress,
    output logic [DW-1:0] WrData,
    output logic          CpuHold,
    output logic          Done,
    output logic          Error,
    output loader_state_t State
);

    // Counter and Remaining carry one extra bit so a full 2**IW frame fits.
    localparam int CW = IW + 1;
    localparam logic [31:0] DEPTH = 32'(1) << IW;

    loader_state_t state, state_n;
    logic [CW-1:0] count, count_n;
    logic [CW-1:0] remaining, remaining_n;
    logic [DW-1:0] acc, acc_n;
    logic          cpu_hold_n, error_n, wr_en_n;
    logic [IW-1:0] wr_addr_n;
    logic [DW-1:0] wr_data_n;
    logic          xfer;
    logic          len_bad;

    // Moore outputs: both depend on state alone.
    assign InReady = (state == LEN) || (state == BODY) || (state == CHK);
    assign Done    = (state == FIN);
    assign State   = state;

    assign xfer    = InValid && InReady;
    assign len_bad = (InData == '0) || (32'(InData) > DEPTH);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            count     <= '0;
            remaining <= '0;
            acc       <= '0;
            CpuHold   <= 1'b0;
            Error     <= 1'b0;
            WrEn      <= 1'b0;
            WrAddress <= '0;
            WrData    <= '0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            remaining <= remaining_n;
            acc       <= acc_n;
            CpuHold   <= cpu_hold_n;
            Error     <= error_n;
            WrEn      <= wr_en_n;
            WrAddress <= wr_addr_n;
            WrData    <= wr_data_n;
        end
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        remaining_n = remaining;
        acc_n       = acc;
        cpu_hold_n  = CpuHold;
        error_n     = Error;
        wr_en_n     = 1'b0;         // strobe only on the edge after a body transfer
        wr_addr_n   = WrAddress;
        wr_data_n   = WrData;

        case (state)
            IDLE: begin
                if (Start) begin
                    state_n    = LEN;
                    cpu_hold_n = 1'b1;
                    error_n    = 1'b0;
                    count_n    = '0;
                    acc_n      = '0;
                end
            end
            LEN: begin
                if (xfer) begin
                    if (len_bad) begin
                        error_n = 1'b1;
                        state_n = FIN;
                    end else begin
                        remaining_n = CW'(InData);
                        state_n     = BODY;
                    end
                end
            end
            BODY: begin
                if (xfer) begin
                    wr_en_n     = 1'b1;
                    wr_addr_n   = count[IW-1:0];
                    wr_data_n   = InData;
                    acc_n       = acc ^ InData;
                    count_n     = count + CW'(1);
                    remaining_n = remaining - CW'(1);
                    // Last body word: remaining is about to hit zero.
                    if (remaining == CW'(1)) begin
                        state_n = CHK;
                    end
                end
            end
            CHK: begin
                if (xfer) begin
                    if (InData != acc) begin
                        error_n = 1'b1;
                    end
                    state_n = FIN;
                end
            end
            FIN: begin
                cpu_hold_n = 1'b0;
                state_n    = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed testbench for inst_loader: normal load, bad checksum, sticky
// error, stalled stream, zero length, mid-session reset and ignored Start.
module tb_inst_loader;
    import inst_loader_pkg::*;

    localparam int IW = 10;
    localparam int DW = 9;

    logic          Clk;
    logic          Reset_n;
    logic          Start;
    logic [DW-1:0] InData;
    logic          InValid;
    logic          InReady;
    logic          WrEn;
    logic [IW-1:0] WrAddress;
    logic [DW-1:0] WrData;
    logic          CpuHold;
    logic          Done;
    logic          Error;
    loader_state_t State;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [IW+DW-1:0] exp_q[$];

    inst_loader #(.IW(IW), .DW(DW)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .InData    (InData),
        .InValid   (InValid),
        .InReady   (InReady),
        .WrEn      (WrEn),
        .WrAddress (WrAddress),
        .WrData    (WrData),
        .CpuHold   (CpuHold),
        .Done      (Done),
        .Error     (Error),
        .State     (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [DW-1:0] data);
        InValid = 1'b1;
        InData  = data;
        tick();
        InValid = 1'b0;
    endtask

    task automatic stall(input int gap);
        for (int i = 0; i < gap; i++) begin
            tick();
            check("stall_wren", 32'(WrEn), 32'd0);
            check("stall_done", 32'(Done), 32'd0);
        end
    endtask

    task automatic start_session();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("start_state", 32'(State), 32'(LEN));
        check("start_hold", 32'(CpuHold), 32'd1);
        check("start_ready", 32'(InReady), 32'd1);
        check("start_err_clr", 32'(Error), 32'd0);
    endtask

    // Three-instruction frame with optional stalls and Start held through BODY.
    task automatic run_frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] chk,
                             input int gap, input logic exp_err, input logic hold_start);
        logic [DW-1:0] words [3];
        logic [IW+DW-1:0] e;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        start_session();
        send_word(9'd3);
        check("len_state", 32'(State), 32'(BODY));
        check("len_wren", 32'(WrEn), 32'd0);
        stall(gap);
        if (hold_start) Start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({IW'(i), words[i]});
            send_word(words[i]);
            e = exp_q.pop_front();
            check("body_wren", 32'(WrEn), 32'd1);
            check("body_addr", 32'(WrAddress), 32'(e[IW+DW-1:DW]));
            check("body_data", 32'(WrData), 32'(e[DW-1:0]));
            check("body_hold", 32'(CpuHold), 32'd1);
            stall(gap);
        end
        Start = 1'b0;
        check("chk_state", 32'(State), 32'(CHK));
        send_word(chk);
        check("fin_done", 32'(Done), 32'd1);
        check("fin_error", 32'(Error), 32'(exp_err));
        check("fin_hold", 32'(CpuHold), 32'd1);
        check("fin_ready", 32'(InReady), 32'd0);
        check("fin_wren", 32'(WrEn), 32'd0);
        tick();
        check("post_done", 32'(Done), 32'd0);
        check("post_hold", 32'(CpuHold), 32'd0);
        check("post_state", 32'(State), 32'(IDLE));
        check("post_error", 32'(Error), 32'(exp_err));
    endtask

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        InValid = 1'b0;
        InData  = '0;

        // Reset values
        tick();
        tick();
        check("rst_state", 32'(State), 32'(IDLE));
        check("rst_ready", 32'(InReady), 32'd0);
        check("rst_wren", 32'(WrEn), 32'd0);
        check("rst_addr", 32'(WrAddress), 32'd0);
        check("rst_data", 32'(WrData), 32'd0);
        check("rst_hold", 32'(CpuHold), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        Reset_n = 1'b1;
        tick();

        // InValid in IDLE consumes nothing
        send_word(9'h055);
        check("idle_state", 32'(State), 32'(IDLE));
        check("idle_wren", 32'(WrEn), 32'd0);
        check("idle_hold", 32'(CpuHold), 32'd0);

        // Normal load: 0x0E0 ^ 0x0B0 ^ 0x091 = 0x0C1
        run_frame(9'h0E0, 9'h0B0, 9'h091, 9'h0C1, 0, 1'b0, 1'b0);

        // Bad checksum, error stays set while idle
        run_frame(9'h0E0, 9'h0B0, 9'h091, 9'h0C0, 0, 1'b1, 1'b0);
        tick();
        tick();
        check("err_sticky", 32'(Error), 32'd1);

        // Next Start clears the error
        run_frame(9'h0E0, 9'h0B0, 9'h091, 9'h0C1, 0, 1'b0, 1'b0);

        // Two-cycle stalls between every word
        run_frame(9'h0E0, 9'h0B0, 9'h091, 9'h0C1, 2, 1'b0, 1'b0);

        // Zero length, Start asserted during FIN is ignored
        start_session();
        send_word(9'd0);
        check("zl_done", 32'(Done), 32'd1);
        check("zl_error", 32'(Error), 32'd1);
        check("zl_wren", 32'(WrEn), 32'd0);
        check("zl_hold", 32'(CpuHold), 32'd1);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("zl_post_done", 32'(Done), 32'd0);
        check("zl_post_hold", 32'(CpuHold), 32'd0);
        check("zl_post_state", 32'(State), 32'(IDLE));
        tick();
        check("zl_fin_start_ign", 32'(State), 32'(IDLE));
        check("zl_err_sticky", 32'(Error), 32'd1);

        // Reset after the second body word
        start_session();
        send_word(9'd3);
        send_word(9'h0E0);
        send_word(9'h0B0);
        check("mid_wren", 32'(WrEn), 32'd1);
        check("mid_addr", 32'(WrAddress), 32'd1);
        Reset_n = 1'b0;
        tick();
        check("mr_state", 32'(State), 32'(IDLE));
        check("mr_ready", 32'(InReady), 32'd0);
        check("mr_wren", 32'(WrEn), 32'd0);
        check("mr_addr", 32'(WrAddress), 32'd0);
        check("mr_data", 32'(WrData), 32'd0);
        check("mr_hold", 32'(CpuHold), 32'd0);
        check("mr_done", 32'(Done), 32'd0);
        check("mr_error", 32'(Error), 32'd0);
        Reset_n = 1'b1;
        tick();
        check("mr_no_done", 32'(Done), 32'd0);
        run_frame(9'h0E0, 9'h0B0, 9'h091, 9'h0C1, 0, 1'b0, 1'b0);

        // Start held high through BODY does not restart the session
        run_frame(9'h0E0, 9'h0B0, 9'h091, 9'h0C1, 0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
